// File: rtl/pc_sequencer.sv
// pc_sequencer: IF-stage program counter with a valid/ready fetch
// handshake and jump/branch redirect selection.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        FetchReady,
  output logic [31:0] PCResult,
  output logic        PCValid,
  output logic [31:0] PCAddResult,
  output logic        Redirected,
  output logic        AlignErr
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic {
    S_BOOT,
    S_RUN
  } state_t;

  state_t      state;
  logic        redir;
  logic [31:0] tgt;
  logic [31:0] pc_nxt;

  always_comb begin
    redir  = Jump | BranchTaken;
    tgt    = Jump ? JumpTarget : BranchTarget;
    pc_nxt = PCResult;
    // Redirects beat Stall; only an accepted fetch steps the PC.
    priority case (1'b1)
      redir:                pc_nxt = {tgt[31:2], 2'b00};
      Stall:                pc_nxt = PCResult;
      PCValid & FetchReady: pc_nxt = PCResult + STEP;
      default:              pc_nxt = PCResult;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_BOOT;
      PCResult    <= RESET_PC;
      PCAddResult <= RESET_PC + STEP;
      PCValid     <= 1'b0;
      Redirected  <= 1'b0;
      AlignErr    <= 1'b0;
    end else begin
      unique case (state)
        S_BOOT: begin
          state   <= S_RUN;
          PCValid <= 1'b1;
        end
        S_RUN: begin
          PCResult    <= pc_nxt;
          PCAddResult <= pc_nxt + STEP;
          Redirected  <= redir;
          if (redir && (tgt[1:0] != 2'b00))
            AlignErr <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scenario tasks with a scoreboard of expected
// fetch-address observations, one per clock.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Stall, BranchTaken, Jump, FetchReady;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] PCResult, PCAddResult;
  logic        PCValid, Redirected, AlignErr;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .FetchReady(FetchReady),
    .PCResult(PCResult), .PCValid(PCValid),
    .PCAddResult(PCAddResult), .Redirected(Redirected),
    .AlignErr(AlignErr)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        rst;
    logic        st;
    logic        bt;
    logic [31:0] btgt;
    logic        j;
    logic [31:0] jtgt;
    logic        fr;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] add;
    logic        v;
    logic        r;
    logic        a;
  } obs_t;

  obs_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic stim_t mk_s(logic rst, logic st, logic bt,
                                 logic [31:0] btgt, logic j,
                                 logic [31:0] jtgt, logic fr);
    stim_t s;
    s.rst = rst; s.st = st; s.bt = bt; s.btgt = btgt;
    s.j = j; s.jtgt = jtgt; s.fr = fr;
    return s;
  endfunction

  function automatic obs_t mk_o(logic [31:0] pc, logic v,
                                logic r, logic a);
    obs_t o;
    o.pc = pc; o.add = pc + 32'd4; o.v = v; o.r = r; o.a = a;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc = PCResult; o.add = PCAddResult;
    o.v = PCValid; o.r = Redirected; o.a = AlignErr;
    return o;
  endfunction

  task automatic drive(input stim_t s, input obs_t e);
    Reset = s.rst; Stall = s.st;
    BranchTaken = s.bt; BranchTarget = s.btgt;
    Jump = s.j; JumpTarget = s.jtgt;
    FetchReady = s.fr;
    sb.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  function automatic stim_t idle(logic fr);
    return mk_s(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, fr);
  endfunction

  task automatic test_reset();
    stim_t s[$]; obs_t e[$]; obs_t g, x;
    s.push_back(mk_s(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
    e.push_back(mk_o(32'h0, 1'b0, 1'b0, 1'b0));
    s.push_back(mk_s(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
    e.push_back(mk_o(32'h0, 1'b0, 1'b0, 1'b0));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h0, 1'b1, 1'b0, 1'b0));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h4, 1'b1, 1'b0, 1'b0));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h8, 1'b1, 1'b0, 1'b0));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'hC, 1'b1, 1'b0, 1'b0));
    foreach (s[i]) begin
      drive(s[i], e[i]);
      g = sample(); x = sb.pop_front(); nvec++;
      if (g !== x) begin
        nerr++;
        $display("FAIL reset[%0d]: got pc=%h add=%h var=%b want pc=%h add=%h var=%b",
                 i, g.pc, g.add, {g.v, g.r, g.a}, x.pc, x.add, {x.v, x.r, x.a});
      end
    end
  endtask

  task automatic test_backpressure();
    stim_t s[$]; obs_t e[$]; obs_t g, x;
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h10, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      s.push_back(idle(1'b0)); e.push_back(mk_o(32'h10, 1'b1, 1'b0, 1'b0));
    end
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h14, 1'b1, 1'b0, 1'b0));
    foreach (s[i]) begin
      drive(s[i], e[i]);
      g = sample(); x = sb.pop_front(); nvec++;
      if (g !== x) begin
        nerr++;
        $display("FAIL backpressure[%0d]: got pc=%h add=%h var=%b want pc=%h add=%h var=%b",
                 i, g.pc, g.add, {g.v, g.r, g.a}, x.pc, x.add, {x.v, x.r, x.a});
      end
    end
  endtask

  task automatic test_redirect_priority();
    stim_t s[$]; obs_t e[$]; obs_t g, x;
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h18, 1'b1, 1'b0, 1'b0));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h1C, 1'b1, 1'b0, 1'b0));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h20, 1'b1, 1'b0, 1'b0));
    s.push_back(mk_s(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h400, 1'b0));
    e.push_back(mk_o(32'h400, 1'b1, 1'b1, 1'b0));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h404, 1'b1, 1'b0, 1'b0));
    s.push_back(mk_s(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0));
    e.push_back(mk_o(32'h100, 1'b1, 1'b1, 1'b0));
    s.push_back(idle(1'b0)); e.push_back(mk_o(32'h100, 1'b1, 1'b0, 1'b0));
    foreach (s[i]) begin
      drive(s[i], e[i]);
      g = sample(); x = sb.pop_front(); nvec++;
      if (g !== x) begin
        nerr++;
        $display("FAIL redirect[%0d]: got pc=%h add=%h var=%b want pc=%h add=%h var=%b",
                 i, g.pc, g.add, {g.v, g.r, g.a}, x.pc, x.add, {x.v, x.r, x.a});
      end
    end
  endtask

  task automatic test_wrap_align();
    stim_t s[$]; obs_t e[$]; obs_t g, x;
    s.push_back(mk_s(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0));
    e.push_back(mk_o(32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h0, 1'b1, 1'b0, 1'b0));
    s.push_back(mk_s(1'b0, 1'b0, 1'b1, 32'h106, 1'b0, 32'h0, 1'b1));
    e.push_back(mk_o(32'h104, 1'b1, 1'b1, 1'b1));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h108, 1'b1, 1'b0, 1'b1));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h10C, 1'b1, 1'b0, 1'b1));
    foreach (s[i]) begin
      drive(s[i], e[i]);
      g = sample(); x = sb.pop_front(); nvec++;
      if (g !== x) begin
        nerr++;
        $display("FAIL wrap_align[%0d]: got pc=%h add=%h var=%b want pc=%h add=%h var=%b",
                 i, g.pc, g.add, {g.v, g.r, g.a}, x.pc, x.add, {x.v, x.r, x.a});
      end
    end
  endtask

  task automatic test_stall();
    stim_t s[$]; obs_t e[$]; obs_t g, x;
    s.push_back(mk_s(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1));
    e.push_back(mk_o(32'h40, 1'b1, 1'b1, 1'b1));
    for (int k = 0; k < 2; k++) begin
      s.push_back(mk_s(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
      e.push_back(mk_o(32'h40, 1'b1, 1'b0, 1'b1));
    end
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h44, 1'b1, 1'b0, 1'b1));
    foreach (s[i]) begin
      drive(s[i], e[i]);
      g = sample(); x = sb.pop_front(); nvec++;
      if (g !== x) begin
        nerr++;
        $display("FAIL stall[%0d]: got pc=%h add=%h var=%b want pc=%h add=%h var=%b",
                 i, g.pc, g.add, {g.v, g.r, g.a}, x.pc, x.add, {x.v, x.r, x.a});
      end
    end
  endtask

  task automatic test_midrun_reset();
    stim_t s[$]; obs_t e[$]; obs_t g, x;
    s.push_back(mk_s(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h88, 1'b1));
    e.push_back(mk_o(32'h88, 1'b1, 1'b1, 1'b1));
    s.push_back(mk_s(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1));
    e.push_back(mk_o(32'h0, 1'b0, 1'b0, 1'b0));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h0, 1'b1, 1'b0, 1'b0));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h4, 1'b1, 1'b0, 1'b0));
    foreach (s[i]) begin
      drive(s[i], e[i]);
      g = sample(); x = sb.pop_front(); nvec++;
      if (g !== x) begin
        nerr++;
        $display("FAIL midrun_reset[%0d]: got pc=%h add=%h var=%b want pc=%h add=%h var=%b",
                 i, g.pc, g.add, {g.v, g.r, g.a}, x.pc, x.add, {x.v, x.r, x.a});
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$]; obs_t e[$]; obs_t g, x;
    s.push_back(mk_s(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h303, 1'b1));
    e.push_back(mk_o(32'h300, 1'b1, 1'b1, 1'b1));
    s.push_back(mk_s(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1));
    e.push_back(mk_o(32'h500, 1'b1, 1'b1, 1'b1));
    s.push_back(idle(1'b1)); e.push_back(mk_o(32'h504, 1'b1, 1'b0, 1'b1));
    foreach (s[i]) begin
      drive(s[i], e[i]);
      g = sample(); x = sb.pop_front(); nvec++;
      if (g !== x) begin
        nerr++;
        $display("FAIL back_to_back[%0d]: got pc=%h add=%h var=%b want pc=%h add=%h var=%b",
                 i, g.pc, g.add, {g.v, g.r, g.a}, x.pc, x.add, {x.v, x.r, x.a});
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
    BranchTarget = 32'h0; JumpTarget = 32'h0; FetchReady = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect_priority();
    test_wrap_align();
    test_stall();
    test_midrun_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
